// File: rtl/eq_compare_sequencer_pkg.sv
// Shared types and constants for the sliced equality comparator.
package eq_compare_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_SLICE = 6;
  localparam int DEF_WIDTH = 24;

  // Slice index width; a single-slice configuration still needs one bit.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/eq_compare_sequencer_eq_slice.sv
// Shared SLICE-bit XNOR equality slice; all ones means the slices match.
module eq_slice
  import eq_compare_sequencer_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] mask
);

  always_comb begin
    mask = ~(a ^ b);
  end

endmodule

// File: rtl/eq_compare_sequencer.sv
// Multi-cycle wide equality compare: steps one shared slice upward from
// slice 0 and stops at the first mismatching slice.
module eq_compare_sequencer
  import eq_compare_sequencer_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int SLICE  = DEF_SLICE,
  localparam int NSLICE = WIDTH / SLICE,
  localparam int IDXW   = idx_width(WIDTH / SLICE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IDXW-1:0]  mismatch_idx,
  output logic [SLICE-1:0] slice_mask
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] mask;

  always_comb begin
    a_sl = a_reg[int'(idx)*SLICE +: SLICE];
    b_sl = b_reg[int'(idx)*SLICE +: SLICE];
  end

  eq_slice #(.SLICE(SLICE)) u_eq_slice (
    .a    (a_sl),
    .b    (b_sl),
    .mask (mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      mismatch_idx <= '0;
      slice_mask   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg        <= a;
            b_reg        <= b;
            idx          <= '0;
            equal        <= 1'b0;
            mismatch_idx <= '0;
            slice_mask   <= '0;
            busy         <= 1'b1;
            state        <= CMP;
          end
        end
        CMP: begin
          slice_mask <= mask;
          if (mask != '1) begin
            equal        <= 1'b0;
            mismatch_idx <= idx;
            done         <= 1'b1;
            state        <= DONE;
          end else if (idx == LAST_IDX) begin
            equal        <= 1'b1;
            mismatch_idx <= '0;
            done         <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
